tt_probe_capture: RTL and testbench

Parametrised on-chip capture harness for the `tt_um_falcon` tile. It samples one of `NCH` probe channels into a `DEPTH`-entry buffer around a trigger, then plays the samples back one per read strobe over the tile's IO pins. It gives silicon bring-up the same visibility the simulation bench gets from waveform dumping: multi-channel, with an optional pre-trigger window.

---
 rtl/tt_probe_capture.sv | 165 ++++++++++++++++
 tb/tb_tt_probe_capture.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tt_probe_capture.sv
// Trigger-based probe capture: records one selected channel into a circular
// buffer around a trigger and replays it oldest-first, one sample per read strobe.
module tt_probe_capture #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int NCH   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic [NCH*WIDTH-1:0]       probe_in,
    input  logic [$clog2(NCH)-1:0]     ch_sel,
    input  logic                       mode,
    input  logic                       arm,
    input  logic                       trig,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     cap_len,
    output logic [1:0]                 state
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CSW   = $clog2(NCH);
    localparam int NSLOT = 1 << CSW;
    localparam logic [AW:0]   FULL_LEN = (AW+1)'(DEPTH);
    localparam logic [AW:0]   HALF_LEN = (AW+1)'(DEPTH / 2);
    localparam logic [AW-1:0] HALF_PTR = AW'(DEPTH / 2);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            state_reg;
    logic [CSW-1:0]    ch_reg;
    logic              mode_reg;
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW-1:0]     pre_cnt_reg;
    logic [AW:0]       post_cnt_reg;
    logic [AW:0]       rd_cnt_reg;
    logic [AW:0]       cap_len_reg;
    logic [WIDTH-1:0]  rd_data_reg;
    logic              rd_valid_reg;
    logic              done_reg;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  chan [NSLOT];
    logic [WIDTH-1:0]  sample;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [AW:0]       post_target;

    // Unused select codes (NCH not a power of two) read as zero.
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_chan
        if (gi < NCH) begin : g_used
            assign chan[gi] = probe_in[gi*WIDTH +: WIDTH];
        end else begin : g_pad
            assign chan[gi] = '0;
        end
    end

    assign sample      = chan[ch_reg];
    assign post_target = mode_reg ? HALF_LEN : FULL_LEN;

    always_comb begin
        we    = 1'b0;
        waddr = wr_ptr_reg;
        if (ena) begin
            case (state_reg)
                S_ARMED: begin
                    if (mode_reg) begin
                        we = 1'b1;
                    end else if (trig) begin
                        we    = 1'b1;
                        waddr = '0;
                    end
                end
                S_CAPTURE: we = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= sample;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            ch_reg       <= '0;
            mode_reg     <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            pre_cnt_reg  <= '0;
            post_cnt_reg <= '0;
            rd_cnt_reg   <= '0;
            cap_len_reg  <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else if (!ena) begin
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= 1'b0;
            if (we) begin
                wr_ptr_reg <= waddr + 1'b1;
            end
            case (state_reg)
                S_IDLE: begin
                    if (arm) begin
                        ch_reg      <= ch_sel;
                        mode_reg    <= mode;
                        wr_ptr_reg  <= '0;
                        pre_cnt_reg <= '0;
                        state_reg   <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (trig) begin
                        post_cnt_reg <= (AW+1)'(1);
                        // Oldest kept entry sits pre-count slots behind the trigger.
                        rd_ptr_reg   <= waddr - pre_cnt_reg;
                        state_reg    <= S_CAPTURE;
                    end else if (mode_reg && pre_cnt_reg != HALF_PTR) begin
                        pre_cnt_reg <= pre_cnt_reg + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    post_cnt_reg <= post_cnt_reg + 1'b1;
                    if (post_cnt_reg + 1'b1 == post_target) begin
                        state_reg   <= S_DONE;
                        done_reg    <= 1'b1;
                        rd_cnt_reg  <= '0;
                        cap_len_reg <= mode_reg ? ({1'b0, pre_cnt_reg} + HALF_LEN) : FULL_LEN;
                    end
                end
                S_DONE: begin
                    if (rd_en) begin
                        rd_data_reg  <= mem[rd_ptr_reg];
                        rd_valid_reg <= 1'b1;
                        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
                        rd_cnt_reg   <= rd_cnt_reg + 1'b1;
                        if (rd_cnt_reg + 1'b1 == cap_len_reg) begin
                            state_reg <= S_IDLE;
                            done_reg  <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;
    assign done     = done_reg;
    assign cap_len  = cap_len_reg;
    assign state    = state_reg;
endmodule

// File: tb/tb_tt_probe_capture.sv
// Directed bench for tt_probe_capture: reset, mode 0/1 captures, ena gaps and corners.
module tb_tt_probe_capture;
    localparam int W = 8;
    localparam int D = 16;
    localparam int N = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ena;
    logic [N*W-1:0]  probe_in;
    logic [0:0]      ch_sel;
    logic            mode;
    logic            arm;
    logic            trig;
    logic            rd_en;
    logic [W-1:0]    rd_data;
    logic            rd_valid;
    logic            done;
    logic [4:0]      cap_len;
    logic [1:0]      state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tt_probe_capture #(.WIDTH(W), .DEPTH(D), .NCH(N)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .probe_in(probe_in),
        .ch_sel(ch_sel), .mode(mode), .arm(arm), .trig(trig), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
        .cap_len(cap_len), .state(state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_probe(input logic [7:0] c0, input logic [7:0] c1);
        probe_in = {c1, c0};
    endtask

    // Full mode-0 capture with ch0 counting through base, then 16 reads.
    task automatic run_mode0(input logic [7:0] base);
        ch_sel = 1'b0; mode = 1'b0; arm = 1'b1;
        set_probe(8'(base - 8'd4), 8'(~(base - 8'd4)));
        tick();
        check("m0_armed", 32'(state), 32'd1);
        arm = 1'b0; ch_sel = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            set_probe(8'(base - 8'(i)), 8'(~(base - 8'(i))));
            tick();
        end
        check("m0_wait", 32'(state), 32'd1);
        trig = 1'b1; set_probe(base, ~base);
        tick();
        trig = 1'b0;
        check("m0_capture", 32'(state), 32'd2);
        for (int i = 1; i <= 15; i++) begin
            set_probe(8'(base + 8'(i)), 8'(~(base + 8'(i))));
            tick();
            if (i == 14) check("m0_done_early", 32'(done), 32'd0);
        end
        check("m0_done", 32'(done), 32'd1);
        check("m0_state3", 32'(state), 32'd3);
        check("m0_caplen", 32'(cap_len), 32'd16);
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check($sformatf("m0_valid%0d", i), 32'(rd_valid), 32'd1);
            check($sformatf("m0_rd%0d", i), 32'(rd_data), 32'(8'(base + 8'(i))));
        end
        rd_en = 1'b0;
        check("m0_idle", 32'(state), 32'd0);
        check("m0_done_drop", 32'(done), 32'd0);
        tick();
        check("m0_valid_end", 32'(rd_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] base;
        rst_n = 1'b0; ena = 1'b1;
        for (int i = 0; i < 2; i++) begin
            probe_in = 16'($urandom); ch_sel = 1'($urandom); mode = 1'($urandom);
            arm = 1'($urandom); trig = 1'($urandom); rd_en = 1'($urandom);
            tick();
        end
        check("rst_state", 32'(state), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_data", 32'(rd_data), 32'd0);
        check("rst_caplen", 32'(cap_len), 32'd0);
        rst_n = 1'b1; probe_in = '0; ch_sel = 1'b0; mode = 1'b0;
        arm = 1'b0; trig = 1'b0; rd_en = 1'b0;
        tick();

        run_mode0(8'h20);

        // Mode 1: ch1 counts from 0 on the first armed edge, ch0 parked at 0xFF.
        ch_sel = 1'b1; mode = 1'b1; arm = 1'b1; set_probe(8'hFF, 8'hEE);
        tick();
        arm = 1'b0; ch_sel = 1'b0; mode = 1'b0;
        check("m1_armed", 32'(state), 32'd1);
        for (int n = 0; n < 20; n++) begin
            set_probe(8'hFF, 8'(n));
            rd_en = (n == 5);
            tick();
            if (n == 5) check("armed_rd_ignored", 32'(rd_valid), 32'd0);
        end
        rd_en = 1'b0;
        trig = 1'b1; set_probe(8'hFF, 8'h14);
        tick();
        trig = 1'b0;
        for (int n = 21; n <= 27; n++) begin
            set_probe(8'hFF, 8'(n));
            tick();
        end
        check("m1_done", 32'(done), 32'd1);
        check("m1_caplen", 32'(cap_len), 32'd16);
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check($sformatf("m1_rd%0d", i), 32'(rd_data), 32'(8'h0C + i));
        end
        rd_en = 1'b0;
        check("m1_idle", 32'(state), 32'd0);
        tick();

        // Mode 1 early trigger, with arm+trig coinciding in IDLE.
        ch_sel = 1'b1; mode = 1'b1; arm = 1'b1; trig = 1'b1; set_probe(8'hFF, 8'hEE);
        tick();
        arm = 1'b0; trig = 1'b0;
        check("armtrig_state", 32'(state), 32'd1);
        for (int n = 0; n < 3; n++) begin
            set_probe(8'hFF, 8'(n));
            tick();
        end
        check("early_still_armed", 32'(state), 32'd1);
        trig = 1'b1; set_probe(8'hFF, 8'h03);
        tick();
        trig = 1'b0;
        for (int n = 4; n <= 10; n++) begin
            set_probe(8'hFF, 8'(n));
            tick();
        end
        check("early_done", 32'(done), 32'd1);
        check("early_caplen", 32'(cap_len), 32'd11);
        rd_en = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            check($sformatf("early_rd%0d", i), 32'(rd_data), 32'(i));
        end
        rd_en = 1'b0;
        check("early_idle", 32'(state), 32'd0);
        tick();

        // Mode 0 with a 5-cycle ena gap after 4 stored samples.
        base = 8'h40;
        ch_sel = 1'b0; mode = 1'b0; arm = 1'b1; set_probe(8'(base - 8'd2), 8'h00);
        tick();
        arm = 1'b0;
        set_probe(8'(base - 8'd1), 8'h00);
        tick();
        trig = 1'b1; set_probe(base, 8'h00);
        tick();
        trig = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            set_probe(8'(base + 8'(j)), 8'h00);
            tick();
        end
        ena = 1'b0;
        for (int j = 4; j <= 8; j++) begin
            set_probe(8'(base + 8'(j)), 8'h00);
            tick();
            check($sformatf("gap_state%0d", j), 32'(state), 32'd2);
        end
        ena = 1'b1;
        for (int j = 9; j <= 20; j++) begin
            set_probe(8'(base + 8'(j)), 8'h00);
            tick();
            if (j == 19) check("gap_done_early", 32'(done), 32'd0);
        end
        check("gap_done", 32'(done), 32'd1);
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) begin
                ena = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    tick();
                    check("gap_rd_valid_off", 32'(rd_valid), 32'd0);
                    check("gap_rd_hold", 32'(state), 32'd3);
                end
                ena = 1'b1;
            end
            tick();
            check($sformatf("gap_rd%0d", i), 32'(rd_data),
                  32'(8'(base + 8'(i < 4 ? i : i + 5))));
        end
        rd_en = 1'b0;
        check("gap_idle", 32'(state), 32'd0);
        tick();

        // Reset in the middle of a capture, then a clean capture.
        ch_sel = 1'b0; mode = 1'b0; arm = 1'b1; set_probe(8'h60, 8'h00);
        tick();
        arm = 1'b0; trig = 1'b1;
        tick();
        trig = 1'b0;
        for (int j = 0; j < 5; j++) tick();
        check("mid_capture", 32'(state), 32'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_caplen", 32'(cap_len), 32'd0);
        tick();
        run_mode0(8'h80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
